// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Included by the loader top level, its word packer and its bench.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// Stream handshake: a byte transfers on a rising edge where i_byte_valid and
// o_byte_ready are both 1; the source holds i_byte_data stable while valid is
// high, and o_byte_ready never depends combinationally on i_byte_valid.
interface imem_loader_if #(
    parameter int ADDR_W = 13
) ();
    logic              i_byte_valid;
    logic [7:0]        i_byte_data;
    logic              o_byte_ready;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [31:0]       o_wdata;

    // Loader side: sinks the stream and drives the memory write port.
    modport master (
        input  i_byte_valid, i_byte_data,
        output o_byte_ready, o_we, o_waddr, o_wdata
    );

    // Environment side: byte source and instruction memory.
    modport slave (
        output i_byte_valid, i_byte_data,
        input  o_byte_ready, o_we, o_waddr, o_wdata
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses
// combinationally in the cycle the last lane is accepted.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane_q;
    logic [23:0]       sr_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane_q <= '0;
            sr_q   <= '0;
        end else if (accept) begin
            lane_q <= lane_q + 1'b1;
            // The top lane never needs storing: it completes the word directly.
            if (lane_q != LAST_LANE) begin
                sr_q[8*lane_q +: 8] <= data;
            end
        end
    end

    assign word       = {data, sr_q};
    assign word_valid = accept && (lane_q == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed, XOR-checksummed byte stream to the
// instruction memory, holding the core until a complete image is written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS   = 2048,
    parameter int ADDR_W        = 13,
    parameter int HOLD_ON_RESET = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    imem_loader_if.master bus,
    output logic          o_core_hold,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output loader_state_e o_state
);
    localparam int         CNT_W   = $clog2(DEPTH_WORDS) + 1;
    localparam logic [15:0] MAX_LEN = 16'(DEPTH_WORDS);

    loader_state_e     state_q, state_d;
    logic [15:0]       len_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [7:0]        chk_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;

    logic        accept;
    logic        start_ok;
    logic        last_word;
    logic [15:0] len_rx;
    logic [31:0] word;
    logic        word_valid;

    assign accept    = bus.i_byte_valid && bus.o_byte_ready;
    assign start_ok  = i_start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign len_rx    = {bus.i_byte_data, len_q[7:0]};
    assign last_word = (16'(word_cnt_q) + 16'd1 == len_q);

    word_packer u_packer (
        .clk        (i_clk),
        .rst        (i_reset),
        .data       (bus.i_byte_data),
        .accept     (accept && state_q == DATA),
        .clear      (start_ok),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: if (start_ok) state_d = LEN_LO;
            LEN_LO:            if (accept) state_d = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (len_rx > MAX_LEN)   state_d = ERROR;
                    else if (len_rx == '0) state_d = CHECK;
                    else                   state_d = DATA;
                end
            end
            DATA:              if (word_valid && last_word) state_d = CHECK;
            CHECK: begin
                if (accept) state_d = (bus.i_byte_data == chk_q) ? DONE : ERROR;
            end
            default:           state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            chk_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= word_valid;
            if (word_valid) begin
                waddr_q    <= ADDR_W'({word_cnt_q, 2'b00});
                wdata_q    <= word;
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            if (start_ok) begin
                word_cnt_q <= '0;
                chk_q      <= '0;
            end
            if (accept) begin
                case (state_q)
                    LEN_LO:  len_q[7:0]  <= bus.i_byte_data;
                    LEN_HI:  len_q[15:8] <= bus.i_byte_data;
                    DATA:    chk_q       <= chk_q ^ bus.i_byte_data;
                    default: ;
                endcase
            end
        end
    end

    assign o_busy       = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                          (state_q == DATA)   || (state_q == CHECK);
    assign o_done       = (state_q == DONE);
    assign o_err        = (state_q == ERROR);
    // A failed image must never be executed, whatever the reset policy.
    assign o_core_hold  = o_done ? 1'b0 :
                          (o_err || o_busy) ? 1'b1 : (HOLD_ON_RESET != 0);
    assign o_state      = state_q;

    assign bus.o_byte_ready = o_busy;
    assign bus.o_we         = we_q;
    assign bus.o_waddr      = waddr_q;
    assign bus.o_wdata      = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: image-level reference model feeds an
// expected-write queue, a negedge monitor checks every memory write.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 13;
    localparam int EW     = ADDR_W + 32;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic          o_core_hold, o_busy, o_done, o_err;
    loader_state_e o_state;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .DEPTH_WORDS   (DEPTH),
        .ADDR_W        (ADDR_W),
        .HOLD_ON_RESET (1)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .bus         (bus),
        .o_core_hold (o_core_hold),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_state     (o_state)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   img[DEPTH];
    logic          prev_we = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge i_clk) begin
        if (bus.o_we === 1'b1) begin
            check("we_single_cycle", 64'(prev_we), 64'd0);
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("write_addr_data", 64'({bus.o_waddr, bus.o_wdata}), 64'(exp_q.pop_front()));
            end
        end
        prev_we <= bus.o_we;
    end

    function automatic int pick_gap(input int g);
        return (g < 0) ? int'($urandom_range(0, 2)) : g;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        k = 0;
        repeat (gap) begin
            @(negedge i_clk);
            bus.i_byte_valid = 1'b0;
        end
        @(negedge i_clk);
        bus.i_byte_valid = 1'b1;
        bus.i_byte_data  = b;
        while (!bus.o_byte_ready && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        check("byte_ready", 64'(bus.o_byte_ready), 64'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge i_clk);
        bus.i_byte_valid = 1'b0;
        while (o_busy && k < 40) begin
            @(negedge i_clk);
            k++;
        end
        check("load_finished", 64'(o_busy), 64'd0);
    endtask

    task automatic check_status(input bit ok);
        check("state",      64'(o_state),      ok ? 64'(DONE) : 64'(ERROR));
        check("done",       64'(o_done),       64'(ok));
        check("err",        64'(o_err),        64'(!ok));
        check("core_hold",  64'(o_core_hold),  64'(!ok));
        check("byte_ready", 64'(bus.o_byte_ready), 64'd0);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    // Reference model: image words -> expected writes, checksum and verdict.
    task automatic run_load(input int n, input int gap, input bit corrupt, input bit noise);
        logic [7:0]  chk;
        logic [15:0] nlen;
        bit          ok;
        nlen = 16'(n);
        chk  = 8'h00;
        ok   = (n <= DEPTH) && !corrupt;
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({ADDR_W'(4 * i), img[i]});
                for (int l = 0; l < 4; l++) chk ^= img[i][8*l +: 8];
            end
        end
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        send_byte(nlen[7:0], pick_gap(gap));
        send_byte(nlen[15:8], pick_gap(gap));
        check("hold_while_busy", 64'(o_core_hold), 64'd1);
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                for (int l = 0; l < 4; l++) begin
                    if (noise) i_start = 1'($urandom_range(0, 1));
                    send_byte(img[i][8*l +: 8], pick_gap(gap));
                end
            end
            i_start = 1'b0;
            send_byte(corrupt ? (chk ^ 8'h01) : chk, pick_gap(gap));
        end
        wait_idle();
        check_status(ok);
    endtask

    initial begin
        bus.i_byte_valid = 1'b0;
        bus.i_byte_data  = 8'h00;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("rst_state",  64'(o_state), 64'(IDLE));
        check("rst_we",     64'(bus.o_we), 64'd0);
        check("rst_waddr",  64'(bus.o_waddr), 64'd0);
        check("rst_wdata",  64'(bus.o_wdata), 64'd0);
        check("rst_ready",  64'(bus.o_byte_ready), 64'd0);
        check("rst_busy",   64'(o_busy), 64'd0);
        check("rst_done",   64'(o_done), 64'd0);
        check("rst_err",    64'(o_err), 64'd0);
        check("rst_hold",   64'(o_core_hold), 64'd1);

        img[0] = 32'h00500013;
        img[1] = 32'h00A00093;
        run_load(2, 0, 1'b0, 1'b0);     // normal load, checksum 0x70
        run_load(2, 0, 1'b1, 1'b0);     // checksum 0x71
        run_load(DEPTH + 1, 0, 1'b0, 1'b0);
        run_load(0, 0, 1'b0, 1'b0);     // 00 00 00
        run_load(0, 0, 1'b1, 1'b0);     // 00 00 01
        run_load(2, 2, 1'b0, 1'b0);     // valid every third cycle

        // Reset one cycle after the 5th payload byte: only word 0 lands.
        exp_q.push_back({ADDR_W'(0), img[0]});
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int j = 0; j < 5; j++) send_byte(img[j / 4][8*(j % 4) +: 8], 0);
        @(negedge i_clk);
        bus.i_byte_valid = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        check("midrst_state", 64'(o_state), 64'(IDLE));
        check("midrst_we",    64'(bus.o_we), 64'd0);
        check("midrst_busy",  64'(o_busy), 64'd0);
        check("midrst_hold",  64'(o_core_hold), 64'd1);
        repeat (5) @(negedge i_clk);
        check("midrst_pending", 64'(exp_q.size()), 64'd0);
        run_load(2, 0, 1'b0, 1'b0);

        repeat (6) begin
            int n;
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) img[i] = $urandom;
            run_load(n, -1, $urandom_range(0, 3) == 0, 1'b1);
        end

        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        run_load(DEPTH, 0, 1'b0, 1'b0); // full depth, last address 0x1FFC

        repeat (3) @(negedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
